// File: rtl/qracc_pkg.sv
// Shared types for the qracc datapath blocks.
//   tile_acc_state_t : FSM states of tile_psum_acc
//   tile_acc_cfg_t   : per-window configuration latched by tile_psum_acc
// The widths below follow the default maxTiles/accBits of tile_psum_acc.
package qracc_pkg;

    localparam int MAX_TILES = 16;
    localparam int ACC_BITS  = 16;
    localparam int TILE_BITS = $clog2(MAX_TILES + 1);
    localparam int SH_BITS   = $clog2(ACC_BITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } tile_acc_state_t;

    typedef struct packed {
        logic [TILE_BITS-1:0] num_tiles;
        logic [SH_BITS-1:0]   out_shift;
    } tile_acc_cfg_t;

endpackage

// File: rtl/tile_psum_acc_if.sv
// Streaming bus of tile_psum_acc: partial-sum input channel and
// requantised output channel.
//   psum_valid_i / psum_ready_o / psum_data_i : partial-sum vectors in
//   out_valid_o  / out_ready_i  / out_data_o  : requantised vectors out
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Once a producer raises valid it holds valid and data
// stable until that transfer; ready may depend combinationally on the
// other side's ready, never on valid.
// The master modport is the producer/consumer environment, the slave
// modport is the accumulator.
interface tile_psum_acc_if #(
    parameter int numCols  = 32,
    parameter int psumBits = 8,
    parameter int outBits  = 8
);
    logic                        psum_valid_i;
    logic                        psum_ready_o;
    logic [numCols*psumBits-1:0] psum_data_i;
    logic                        out_valid_o;
    logic                        out_ready_i;
    logic [numCols*outBits-1:0]  out_data_o;

    modport master (
        output psum_valid_i, psum_data_i, out_ready_i,
        input  psum_ready_o, out_valid_o, out_data_o
    );

    modport slave (
        input  psum_valid_i, psum_data_i, out_ready_i,
        output psum_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/tile_psum_acc_rq.sv
// rq_sat_shift: combinational requantiser for one column.
//   acc_i   : signed accumulator value (accBits)
//   shift_i : arithmetic right-shift amount
//   q_o     : round-half-up shifted value clamped to signed outBits
//   sat_o   : high when the clamp was applied
module rq_sat_shift #(
    parameter  int accBits = 16,
    parameter  int outBits = 8,
    localparam int shBits  = $clog2(accBits)
) (
    input  logic signed [accBits-1:0] acc_i,
    input  logic        [shBits-1:0]  shift_i,
    output logic signed [outBits-1:0] q_o,
    output logic                      sat_o
);
    // One extra bit so adding the rounding constant can never wrap.
    localparam logic signed [accBits:0] R_MAX =
        {{(accBits - outBits + 2){1'b0}}, {(outBits - 1){1'b1}}};
    localparam logic signed [accBits:0] R_MIN =
        {{(accBits - outBits + 2){1'b1}}, {(outBits - 1){1'b0}}};

    logic signed [accBits:0] ext;
    logic signed [accBits:0] rnd;
    logic signed [accBits:0] sum;
    logic signed [accBits:0] r;

    always_comb begin
        ext = {acc_i[accBits-1], acc_i};
        rnd = '0;
        if (shift_i != '0) begin
            rnd = (accBits + 1)'(1) << (shift_i - 1'b1);
        end
        sum   = ext + rnd;
        r     = sum >>> shift_i;
        q_o   = r[outBits-1:0];
        sat_o = 1'b0;
        if (r > R_MAX) begin
            q_o   = {1'b0, {(outBits - 1){1'b1}}};
            sat_o = 1'b1;
        end else if (r < R_MIN) begin
            q_o   = {1'b1, {(outBits - 1){1'b0}}};
            sat_o = 1'b1;
        end
    end
endmodule

// File: rtl/tile_psum_acc.sv
// tile_psum_acc: sums per-column partial sums over a window of row tiles,
// requantises each column (rounding shift + saturate) and presents one
// output vector per window.
//   clk, rst         : clock, synchronous active-high reset
//   cfg_num_tiles_i  : tiles per window (0 -> 1, >maxTiles -> maxTiles)
//   cfg_out_shift_i  : requantisation right shift
//   bus (slave)      : psum input channel and requantised output channel
//   tile_idx_o       : tiles accepted so far in the current window
//   ovf_o            : sticky saturation flag for the current window
//   busy_o           : FSM not idle
//   dbg_state_o      : current FSM state
module tile_psum_acc
    import qracc_pkg::*;
#(
    parameter  int numCols  = 32,
    parameter  int psumBits = 8,
    parameter  int accBits  = ACC_BITS,
    parameter  int outBits  = 8,
    parameter  int maxTiles = MAX_TILES,
    localparam int tileBits = $clog2(maxTiles + 1),
    localparam int shBits   = $clog2(accBits)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [tileBits-1:0]   cfg_num_tiles_i,
    input  logic [shBits-1:0]     cfg_out_shift_i,
    tile_psum_acc_if.slave        bus,
    output logic [tileBits-1:0]   tile_idx_o,
    output logic                  ovf_o,
    output logic                  busy_o,
    output tile_acc_state_t       dbg_state_o
);
    localparam logic signed [accBits:0] A_MAX = {2'b00, {(accBits - 1){1'b1}}};
    localparam logic signed [accBits:0] A_MIN = {2'b11, {(accBits - 1){1'b0}}};

    tile_acc_state_t state;
    tile_acc_cfg_t   cfg_q;

    logic signed [accBits-1:0] acc_q    [numCols];
    logic signed [accBits-1:0] acc_next [numCols];
    logic [numCols-1:0]        acc_sat;
    logic [numCols-1:0]        out_sat;
    logic [numCols*outBits-1:0] rq_data;
    logic [numCols*outBits-1:0] out_data_q;
    logic                      out_valid_q;

    logic                accept;
    logic                first;
    logic                last;
    logic [tileBits-1:0] count_first;
    logic [tileBits-1:0] count_eff;
    logic [shBits-1:0]   shift_eff;
    logic [tileBits-1:0] tile_next;
    logic                ovf_base;

    // While an output is pending, a new tile can only enter together with
    // the output handshake.
    assign bus.psum_ready_o = (state != S_OUT) || bus.out_ready_i;
    assign bus.out_valid_o  = out_valid_q;
    assign bus.out_data_o   = out_data_q;
    assign busy_o           = (state != S_IDLE);
    assign dbg_state_o      = state;

    always_comb begin
        accept = bus.psum_valid_i && bus.psum_ready_o;
        // Any accept outside S_ACC opens a new window.
        first  = accept && (state != S_ACC);

        count_first = cfg_num_tiles_i;
        if (cfg_num_tiles_i == '0) begin
            count_first = tileBits'(1);
        end else if (cfg_num_tiles_i > tileBits'(maxTiles)) begin
            count_first = tileBits'(maxTiles);
        end

        // The first tile of a window uses the live config; later tiles use
        // the copy latched with that first tile.
        count_eff = first ? count_first     : tileBits'(cfg_q.num_tiles);
        shift_eff = first ? cfg_out_shift_i : shBits'(cfg_q.out_shift);
        tile_next = first ? tileBits'(1)    : tile_idx_o + tileBits'(1);
        last      = accept && (tile_next == count_eff);
        ovf_base  = first ? 1'b0 : ovf_o;

        for (int k = 0; k < numCols; k++) begin
            logic signed [accBits:0] base;
            logic signed [accBits:0] addend;
            logic signed [accBits:0] sum;
            base   = first ? '0 : {acc_q[k][accBits-1], acc_q[k]};
            addend = (accBits + 1)'(signed'(bus.psum_data_i[k*psumBits +: psumBits]));
            sum    = base + addend;
            acc_next[k] = sum[accBits-1:0];
            acc_sat[k]  = 1'b0;
            if (sum > A_MAX) begin
                acc_next[k] = {1'b0, {(accBits - 1){1'b1}}};
                acc_sat[k]  = 1'b1;
            end else if (sum < A_MIN) begin
                acc_next[k] = {1'b1, {(accBits - 1){1'b0}}};
                acc_sat[k]  = 1'b1;
            end
        end
    end

    // Requantise the value about to be stored, so out_data is ready the
    // cycle the FSM enters S_OUT.
    for (genvar k = 0; k < numCols; k++) begin : g_rq
        rq_sat_shift #(
            .accBits (accBits),
            .outBits (outBits)
        ) u_rq (
            .acc_i   (acc_next[k]),
            .shift_i (shift_eff),
            .q_o     (rq_data[k*outBits +: outBits]),
            .sat_o   (out_sat[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cfg_q       <= '0;
            tile_idx_o  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_o       <= 1'b0;
            for (int k = 0; k < numCols; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE, S_ACC, S_OUT: begin
                    if (accept) begin
                        for (int k = 0; k < numCols; k++) begin
                            acc_q[k] <= acc_next[k];
                        end
                        tile_idx_o <= tile_next;
                        if (first) begin
                            cfg_q.num_tiles <= TILE_BITS'(count_first);
                            cfg_q.out_shift <= SH_BITS'(cfg_out_shift_i);
                        end
                        if (last) begin
                            state       <= S_OUT;
                            out_valid_q <= 1'b1;
                            out_data_q  <= rq_data;
                            ovf_o       <= ovf_base | (|acc_sat) | (|out_sat);
                        end else begin
                            state       <= S_ACC;
                            out_valid_q <= 1'b0;
                            ovf_o       <= ovf_base | (|acc_sat);
                        end
                    end else if (state == S_OUT && bus.out_ready_i) begin
                        state       <= S_IDLE;
                        tile_idx_o  <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_psum_acc.sv
module tb_tile_psum_acc;
    import qracc_pkg::*;

    localparam int NC = 32;
    localparam int W  = NC * 8;

    logic           clk;
    logic           rst;
    logic [4:0]     cfg_num_tiles;
    logic [3:0]     cfg_out_shift;
    logic [4:0]     tile_idx;
    logic           ovf;
    logic           busy;
    tile_acc_state_t dbg_state;

    int n_checks;
    int n_errors;
    logic [W-1:0] exp_q[$];

    tile_psum_acc_if #(.numCols(NC), .psumBits(8), .outBits(8)) bus ();

    tile_psum_acc dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_num_tiles_i (cfg_num_tiles),
        .cfg_out_shift_i (cfg_out_shift),
        .bus             (bus.slave),
        .tile_idx_o      (tile_idx),
        .ovf_o           (ovf),
        .busy_o          (busy),
        .dbg_state_o     (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] vec_all(input int v);
        logic [W-1:0] r;
        for (int k = 0; k < NC; k++) r[k*8 +: 8] = 8'(v);
        return r;
    endfunction

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        bus.psum_valid_i = 1'b1;
        bus.psum_data_i  = d;
        step();
        bus.psum_valid_i = 1'b0;
    endtask

    task automatic check_out(input string tag);
        logic [W-1:0] e;
        check({tag, "_valid"}, W'(bus.out_valid_o), W'(1));
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, W'(0), W'(1));
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, bus.out_data_o, e);
        end
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] held;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        cfg_num_tiles    = '0;
        cfg_out_shift    = '0;
        bus.psum_valid_i = 1'b0;
        bus.psum_data_i  = '0;
        bus.out_ready_i  = 1'b0;
        repeat (3) step();
        check("rst_out_valid", W'(bus.out_valid_o), W'(0));
        check("rst_out_data", bus.out_data_o, '0);
        check("rst_tile_idx", W'(tile_idx), W'(0));
        check("rst_ovf", W'(ovf), W'(0));
        check("rst_busy", W'(busy), W'(0));
        rst = 1'b0;
        step();
        check("rst_psum_ready", W'(bus.psum_ready_o), W'(1));
        check("rst_state", W'(dbg_state), W'(S_IDLE));

        // 1) single tile, ramp k-16, no shift
        cfg_num_tiles = 5'd1;
        cfg_out_shift = 4'd0;
        for (int k = 0; k < NC; k++) v[k*8 +: 8] = 8'(k - 16);
        exp_q.push_back(v);
        send(v);
        check_out("t1");
        check("t1_ovf", W'(ovf), W'(0));
        check("t1_tile_idx", W'(tile_idx), W'(1));
        bus.out_ready_i = 1'b1;
        step();
        check("t1_drain_valid", W'(bus.out_valid_o), W'(0));
        check("t1_drain_idx", W'(tile_idx), W'(0));
        check("t1_drain_busy", W'(busy), W'(0));

        // 2) four tiles of +100, shift 2; cfg changed mid-window is ignored
        bus.out_ready_i = 1'b0;
        cfg_num_tiles = 5'd4;
        cfg_out_shift = 4'd2;
        for (int t = 1; t <= 4; t++) begin
            if (t == 4) exp_q.push_back(vec_all(100));
            send(vec_all(100));
            cfg_num_tiles = 5'd1;
            cfg_out_shift = 4'd0;
            check($sformatf("t2_idx%0d", t), W'(tile_idx), W'(t));
            if (t < 4) check($sformatf("t2_novalid%0d", t), W'(bus.out_valid_o), W'(0));
        end
        check_out("t2");
        check("t2_ovf", W'(ovf), W'(0));
        check("t2_ready_blocked", W'(bus.psum_ready_o), W'(0));
        bus.out_ready_i = 1'b1;
        step();
        bus.out_ready_i = 1'b0;

        // 3) saturation at output, positive then negative
        cfg_out_shift = 4'd0;
        for (int pass = 0; pass < 2; pass++) begin
            cfg_num_tiles = 5'd4;
            for (int t = 0; t < 4; t++) begin
                if (t == 3) exp_q.push_back(vec_all(pass == 0 ? 127 : -128));
                send(vec_all(pass == 0 ? 127 : -128));
            end
            check_out(pass == 0 ? "t3_pos" : "t3_neg");
            check(pass == 0 ? "t3_pos_ovf" : "t3_neg_ovf", W'(ovf), W'(1));
            bus.out_ready_i = 1'b1;
            step();
            bus.out_ready_i = 1'b0;
            check("t3_ovf_sticky", W'(ovf), W'(1));
        end

        // 4) rounding: even columns +3 -> 2, odd columns -3 -> -1; cfg 0 means 1 tile
        cfg_num_tiles = 5'd0;
        cfg_out_shift = 4'd1;
        for (int k = 0; k < NC; k++) v[k*8 +: 8] = (k % 2 == 0) ? 8'sd3 : -8'sd3;
        for (int k = 0; k < NC; k++) held[k*8 +: 8] = (k % 2 == 0) ? 8'sd2 : -8'sd1;
        exp_q.push_back(held);
        send(v);
        check_out("t4_round");
        check("t4_ovf_cleared", W'(ovf), W'(0));
        bus.out_ready_i = 1'b1;
        step();
        bus.out_ready_i = 1'b0;

        // tile count above maxTiles clamps to 16
        cfg_num_tiles = 5'd31;
        cfg_out_shift = 4'd0;
        for (int t = 1; t <= 16; t++) begin
            if (t == 16) exp_q.push_back(vec_all(16));
            send(vec_all(1));
            if (t == 15) check("clamp_no_valid15", W'(bus.out_valid_o), W'(0));
        end
        check_out("clamp16");
        check("clamp_idx", W'(tile_idx), W'(16));
        bus.out_ready_i = 1'b1;
        step();
        bus.out_ready_i = 1'b0;

        // 5) backpressure then same-cycle handshake + new first tile
        cfg_num_tiles = 5'd1;
        exp_q.push_back(vec_all(-5));
        send(vec_all(-5));
        held = bus.out_data_o;
        check_out("t5_first");
        bus.psum_valid_i = 1'b1;
        bus.psum_data_i  = vec_all(10);
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("t5_stable%0d", c), bus.out_data_o, vec_all(-5));
            check($sformatf("t5_ready%0d", c), W'(bus.psum_ready_o), W'(0));
        end
        check("t5_state_out", W'(dbg_state), W'(S_OUT));
        cfg_num_tiles = 5'd2;
        bus.out_ready_i = 1'b1;
        #1;
        check("t5_ready_release", W'(bus.psum_ready_o), W'(1));
        step();
        bus.out_ready_i = 1'b0;
        check("t5_handoff_valid", W'(bus.out_valid_o), W'(0));
        check("t5_handoff_idx", W'(tile_idx), W'(1));
        check("t5_handoff_busy", W'(busy), W'(1));
        exp_q.push_back(vec_all(20));
        send(vec_all(10));
        check_out("t5_second");
        bus.out_ready_i = 1'b1;
        step();

        // back-to-back single-tile windows with downstream always ready
        cfg_num_tiles = 5'd1;
        bus.psum_valid_i = 1'b1;
        for (int t = 0; t < 3; t++) begin
            bus.psum_data_i = vec_all(t * 7 - 9);
            exp_q.push_back(vec_all(t * 7 - 9));
            step();
            check_out($sformatf("b2b%0d", t));
        end
        bus.psum_valid_i = 1'b0;
        step();
        check("b2b_drain", W'(bus.out_valid_o), W'(0));
        bus.out_ready_i = 1'b0;

        // 6) reset mid-window discards partial sums
        cfg_num_tiles = 5'd4;
        send(vec_all(50));
        send(vec_all(50));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_no_valid", W'(bus.out_valid_o), W'(0));
        check("t6_idx", W'(tile_idx), W'(0));
        check("t6_busy", W'(busy), W'(0));
        cfg_num_tiles = 5'd1;
        exp_q.push_back(vec_all(7));
        send(vec_all(7));
        check_out("t6_fresh");
        bus.out_ready_i = 1'b1;
        step();

        check("queue_empty", W'(exp_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
